// File: rtl/alu_exec_unit_pkg.sv
// Shared constants for the execute-stage ALU block.
// ALU operation codes (gout), R-type funct codes and I-type opcodes
// recognised by the ALU control decoder.
package alu_exec_unit_pkg;

  // gout encoding
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [2:0] ALU_NOR = 3'b100;

  // R-type funct[3:0]
  localparam logic [3:0] FN_ADD = 4'b0000;
  localparam logic [3:0] FN_SUB = 4'b0010;
  localparam logic [3:0] FN_AND = 4'b0100;
  localparam logic [3:0] FN_OR  = 4'b0101;  // also jmnor
  localparam logic [3:0] FN_NOR = 4'b0111;
  localparam logic [3:0] FN_SLT = 4'b1010;

  // I-type logic opcodes
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_SLTI = 6'b001010;

endpackage

// File: rtl/adder32.sv
// Plain 32-bit wrap-around adder, used for pc+4 and the branch target.
// Ports: a, b operands; sum = a + b mod 2^32.
module adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/alu_ctrl_decode.sv
// ALU control decoder: maps the main-control op class plus funct/opcode
// onto the 3-bit ALU operation.
// Ports: aluop1/aluop0 op class, funct instr[3:0], opcode instr[31:26],
//        gout decoded ALU operation.
module alu_ctrl_decode
  import alu_exec_unit_pkg::*;
(
  input  logic       aluop1,
  input  logic       aluop0,
  input  logic [3:0] funct,
  input  logic [5:0] opcode,
  output logic [2:0] gout
);

  always_comb begin
    gout = ALU_ADD;
    unique case ({aluop1, aluop0})
      2'b00: gout = ALU_ADD;
      2'b01: gout = ALU_SUB;
      2'b10: begin
        case (funct)
          FN_ADD:  gout = ALU_ADD;
          FN_SUB:  gout = ALU_SUB;
          FN_AND:  gout = ALU_AND;
          FN_OR:   gout = ALU_OR;
          FN_NOR:  gout = ALU_NOR;
          FN_SLT:  gout = ALU_SLT;
          default: gout = ALU_ADD;
        endcase
      end
      2'b11: begin
        case (opcode)
          OP_ORI:  gout = ALU_OR;
          OP_ANDI: gout = ALU_AND;
          OP_SLTI: gout = ALU_SLT;
          default: gout = ALU_ADD;
        endcase
      end
      default: gout = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage arithmetic block: ALU control decode, 32-bit ALU with
// zero/overflow/negative flags, pc+4 and branch-target adders, and a
// V/Z/N status register holding the previous cycle's flags.
// Ports: clk, reset (async, active-high); a, b operands; aluop1/aluop0,
//        funct, opcode decode inputs; pc, imm16 for the adders;
//        gout, result, zero, overflow, negative (combinational);
//        v_flag, z_flag, n_flag (registered); pc_plus4, branch_target.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        aluop1,
  input  logic        aluop0,
  input  logic [3:0]  funct,
  input  logic [5:0]  opcode,
  input  logic [31:0] pc,
  input  logic [15:0] imm16,
  output logic [2:0]  gout,
  output logic [31:0] result,
  output logic        zero,
  output logic        overflow,
  output logic        negative,
  output logic        v_flag,
  output logic        z_flag,
  output logic        n_flag,
  output logic [31:0] pc_plus4,
  output logic [31:0] branch_target
);

  alu_ctrl_decode u_dec (
    .aluop1 (aluop1),
    .aluop0 (aluop0),
    .funct  (funct),
    .opcode (opcode),
    .gout   (gout)
  );

  logic [31:0] sum, diff;
  logic        slt;

  assign sum  = a + b;
  assign diff = a - b;
  // Sign-mismatch case decides SLT directly, so it stays right when a-b overflows.
  assign slt  = (a[31] != b[31]) ? a[31] : diff[31];

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (gout)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_NOR: result = ~(a | b);
      ALU_ADD: begin
        result   = sum;
        overflow = (a[31] == b[31]) && (sum[31] != a[31]);
      end
      ALU_SUB: begin
        result   = diff;
        overflow = (a[31] != b[31]) && (diff[31] != a[31]);
      end
      ALU_SLT: result = {31'd0, slt};
      default: result = '0;
    endcase
  end

  assign zero     = (result == '0);
  assign negative = result[31];

  adder32 u_pc4 (
    .a   (pc),
    .b   (32'd4),
    .sum (pc_plus4)
  );

  adder32 u_br (
    .a   (pc_plus4),
    .b   ({{14{imm16[15]}}, imm16, 2'b00}),
    .sum (branch_target)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_flag <= 1'b0;
      z_flag <= 1'b0;
      n_flag <= 1'b0;
    end else begin
      v_flag <= overflow;
      z_flag <= zero;
      n_flag <= negative;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a, b, pc;
  logic        aluop1, aluop0;
  logic [3:0]  funct;
  logic [5:0]  opcode;
  logic [15:0] imm16;
  logic [2:0]  gout;
  logic [31:0] result, pc_plus4, branch_target;
  logic        zero, overflow, negative, v_flag, z_flag, n_flag;

  int checks = 0;
  int failures = 0;

  alu_exec_unit dut (
    .clk           (clk),
    .reset         (reset),
    .a             (a),
    .b             (b),
    .aluop1        (aluop1),
    .aluop0        (aluop0),
    .funct         (funct),
    .opcode        (opcode),
    .pc            (pc),
    .imm16         (imm16),
    .gout          (gout),
    .result        (result),
    .zero          (zero),
    .overflow      (overflow),
    .negative      (negative),
    .v_flag        (v_flag),
    .z_flag        (z_flag),
    .n_flag        (n_flag),
    .pc_plus4      (pc_plus4),
    .branch_target (branch_target)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic alu(input logic [1:0] op, input logic [3:0] fn, input logic [5:0] opc,
                     input logic [31:0] ia, input logic [31:0] ib);
    @(negedge clk);
    {aluop1, aluop0} = op;
    funct = fn; opcode = opc; a = ia; b = ib;
    #1;
  endtask

  task automatic flags(input string tag, input logic v, input logic z, input logic n);
    chk({tag, "_v"}, 32'(v_flag), 32'(v));
    chk({tag, "_z"}, 32'(z_flag), 32'(z));
    chk({tag, "_n"}, 32'(n_flag), 32'(n));
  endtask

  initial begin
    reset = 1'b1;
    a = '0; b = '0; pc = '0; imm16 = '0;
    aluop1 = 1'b0; aluop0 = 1'b0; funct = '0; opcode = '0;
    #2;
    flags("rst", 1'b0, 1'b0, 1'b0);
    @(negedge clk); reset = 1'b0;

    // ADD overflow
    alu(2'b10, 4'b0000, 6'd0, 32'h7FFFFFFF, 32'h00000001);
    chk("add_gout", 32'(gout), 32'h2);
    chk("add_res", result, 32'h80000000);
    chk("add_ovf", 32'(overflow), 32'h1);
    chk("add_neg", 32'(negative), 32'h1);
    chk("add_zero", 32'(zero), 32'h0);
    @(posedge clk); #1;
    flags("add_flg", 1'b1, 1'b0, 1'b1);

    // ADD negative overflow wraps to zero
    alu(2'b00, 4'b1111, 6'd0, 32'h80000000, 32'h80000000);
    chk("addn_gout", 32'(gout), 32'h2);
    chk("addn_res", result, 32'h0);
    chk("addn_ovf", 32'(overflow), 32'h1);
    chk("addn_zero", 32'(zero), 32'h1);

    // SUB equal operands
    alu(2'b01, 4'b0000, 6'd0, 32'h12345678, 32'h12345678);
    chk("subeq_gout", 32'(gout), 32'h6);
    chk("subeq_res", result, 32'h0);
    chk("subeq_zero", 32'(zero), 32'h1);
    chk("subeq_ovf", 32'(overflow), 32'h0);
    @(posedge clk); #1;
    flags("subeq_flg", 1'b0, 1'b1, 1'b0);

    // SUB overflow
    alu(2'b01, 4'b0000, 6'd0, 32'h80000000, 32'h00000001);
    chk("subov_res", result, 32'h7FFFFFFF);
    chk("subov_ovf", 32'(overflow), 32'h1);
    chk("subov_neg", 32'(negative), 32'h0);
    // R-type SUB without overflow
    alu(2'b10, 4'b0010, 6'd0, 32'h00000005, 32'h00000007);
    chk("sub_gout", 32'(gout), 32'h6);
    chk("sub_res", result, 32'hFFFFFFFE);
    chk("sub_ovf", 32'(overflow), 32'h0);

    // SLT across overflow boundary
    alu(2'b10, 4'b1010, 6'd0, 32'h80000000, 32'h7FFFFFFF);
    chk("slt_gout", 32'(gout), 32'h7);
    chk("slt_res", result, 32'h1);
    chk("slt_ovf", 32'(overflow), 32'h0);
    alu(2'b10, 4'b1010, 6'd0, 32'h7FFFFFFF, 32'h80000000);
    chk("slt_swap", result, 32'h0);
    alu(2'b10, 4'b1010, 6'd0, 32'h00000003, 32'h00000009);
    chk("slt_pos", result, 32'h1);

    // Logic ops
    alu(2'b10, 4'b0100, 6'd0, 32'hF0F0F0F0, 32'h0FF00FF0);
    chk("and_gout", 32'(gout), 32'h0);
    chk("and_res", result, 32'h00F000F0);
    alu(2'b10, 4'b0101, 6'd0, 32'hF0F0F0F0, 32'h0FF00FF0);
    chk("or_gout", 32'(gout), 32'h1);
    chk("or_res", result, 32'hFFF0FFF0);
    alu(2'b10, 4'b0111, 6'd0, 32'hF0F0F0F0, 32'h0FF00FF0);
    chk("nor_gout", 32'(gout), 32'h4);
    chk("nor_res", result, 32'h000F000F);
    chk("nor_ovf", 32'(overflow), 32'h0);
    alu(2'b11, 4'b0000, 6'b001101, 32'hF0F0F0F0, 32'h0FF00FF0);
    chk("ori_gout", 32'(gout), 32'h1);
    chk("ori_res", result, 32'hFFF0FFF0);
    alu(2'b11, 4'b0000, 6'b001100, 32'hF0F0F0F0, 32'h0FF00FF0);
    chk("andi_gout", 32'(gout), 32'h0);
    alu(2'b11, 4'b0000, 6'b001010, 32'hF0F0F0F0, 32'h0FF00FF0);
    chk("slti_gout", 32'(gout), 32'h7);
    chk("slti_res", result, 32'h1);
    alu(2'b11, 4'b0000, 6'b100011, 32'hF0F0F0F0, 32'h0FF00FF0);
    chk("iother_gout", 32'(gout), 32'h2);
    alu(2'b10, 4'b1111, 6'd0, 32'hF0F0F0F0, 32'h0FF00FF0);
    chk("fother_gout", 32'(gout), 32'h2);
    chk("fother_res", result, 32'h00E100E0);
    chk("fother_ovf", 32'(overflow), 32'h0);

    // Adders
    pc = 32'h00000010; imm16 = 16'hFFFE; #1;
    chk("pc4_a", pc_plus4, 32'h00000014);
    chk("bt_a", branch_target, 32'h0000000C);
    pc = 32'hFFFFFFFC; imm16 = 16'h0004; #1;
    chk("pc4_wrap", pc_plus4, 32'h00000000);
    chk("bt_wrap", branch_target, 32'h00000010);
    pc = 32'h00000000; imm16 = 16'h7FFF; #1;
    chk("bt_pos", branch_target, 32'h00020000);

    // Reset between edges
    alu(2'b10, 4'b0000, 6'd0, 32'h7FFFFFFF, 32'h00000001);
    @(posedge clk); #1;
    flags("pre_rst", 1'b1, 1'b0, 1'b1);
    #2 reset = 1'b1;
    #1;
    flags("rst_async", 1'b0, 1'b0, 1'b0);
    chk("rst_comb_res", result, 32'h80000000);
    @(posedge clk); #1;
    flags("rst_hold1", 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    flags("rst_hold2", 1'b0, 1'b0, 1'b0);
    @(negedge clk); reset = 1'b0;
    #1;
    flags("rst_rel", 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    flags("post_rst", 1'b1, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
